// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one row at a time, debounces the
//   press and the release, and reports each accepted key once.
//
// Ports
//   clk        system clock (25 MHz on the board)
//   nRst       asynchronous reset, active-high despite the name
//   key_col    keypad columns, active-low, asynchronous to clk
//   key_row    row drive, one-hot active-low
//   key_code   last accepted key {row_idx, col_idx}; held until the next press
//   key_valid  one-cycle strobe when a new press is accepted
//   key_held   high while the accepted key is still considered pressed
module keypad_scanner #(
    parameter int SCAN_DIV  = 25000,
    parameter int DEB_TICKS = 20,
    parameter int CNT_W     = 15
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t           state;
    logic [CNT_W-1:0] pre_cnt;
    logic [DW-1:0]    deb_cnt;
    logic [1:0]       row_idx;
    logic [1:0]       cap_col;
    logic [3:0]       col_m;
    logic [3:0]       col_s;
    logic             tick;
    logic             pressed;
    logic [1:0]       col_idx;
    logic [1:0]       next_row;

    // Two-flop synchroniser; nothing downstream looks at key_col directly.
    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
        end else begin
            col_m <= key_col;
            col_s <= col_m;
        end
    end

    // Free-running scan prescaler, independent of FSM state.
    always_ff @(posedge clk or posedge nRst) begin
        if (nRst)
            pre_cnt <= '0;
        else if (pre_cnt == SCAN_LAST)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick     = (pre_cnt == SCAN_LAST);
    assign pressed  = ~&col_s;
    assign next_row = row_idx + 2'd1;

    // Lowest low column wins when several are pressed together.
    always_comb begin
        col_idx = 2'd0;
        if (!col_s[0])      col_idx = 2'd0;
        else if (!col_s[1]) col_idx = 2'd1;
        else if (!col_s[2]) col_idx = 2'd2;
        else if (!col_s[3]) col_idx = 2'd3;
    end

    // Row drive only moves on when the FSM returns to/continues scanning, so
    // a detected key keeps its row energised through debounce and hold.
    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            key_row   <= 4'b1110;
            cap_col   <= 2'd0;
            deb_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (pressed) begin
                            cap_col <= col_idx;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            row_idx <= next_row;
                            key_row <= ~(4'b0001 << next_row);
                        end
                    end
                    DEBOUNCE: begin
                        if (pressed && col_idx == cap_col) begin
                            if (deb_cnt == DEB_LAST) begin
                                key_code  <= {row_idx, cap_col};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            state   <= SCAN;
                            row_idx <= next_row;
                            key_row <= ~(4'b0001 << next_row);
                        end
                    end
                    HELD: begin
                        // Only the captured column matters; other keys on
                        // this row are deliberately ignored.
                        if (col_s[cap_col]) begin
                            if (deb_cnt == DEB_LAST) begin
                                key_held <= 1'b0;
                                deb_cnt  <= '0;
                                state    <= SCAN;
                                row_idx  <= next_row;
                                key_row  <= ~(4'b0001 << next_row);
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            deb_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_TICKS = 3;
    localparam int CNT_W     = 3;

    logic             clk = 1'b0;
    logic             nRst = 1'b1;
    logic [3:0]       key_col;
    logic [3:0]       key_row;
    logic [3:0]       key_code;
    logic             key_valid;
    logic             key_held;
    logic [3:0][3:0]  keys = '0;   // keys[row][col] = 1 when that switch is closed
    logic [3:0]       exp_q[$];
    logic             mon_prev = 1'b0;
    int               checks = 0;
    int               errors = 0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) dut (
        .clk(clk), .nRst(nRst), .key_col(key_col), .key_row(key_row),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Matrix model: a closed switch pulls its column low only while its row is driven.
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r][c] && !key_row[r]) key_col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_held(input logic v, input int bound, input string name);
        int n = 0;
        while (key_held !== v && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, key_held}, {31'd0, v});
    endtask

    task automatic wait_row(input logic [3:0] v, input int bound, input string name);
        int n = 0;
        while (key_row !== v && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, key_row, v);
    endtask

    // Monitor: every key_valid must match the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_prev) check("valid_one_cycle", {31'd0, key_valid}, 32'd0);
            if (!nRst && key_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual code=%0h expected no strobe", key_code);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("valid_code", key_code, e);
                    check("valid_held", {31'd0, key_held}, 32'd1);
                end
            end
            mon_prev = key_valid;
        end
    end

    initial begin
        logic [3:0] prev;
        int since, changes, n;

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        check("rst_row", key_row, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        nRst = 1'b0;

        // Idle scan: rotate one row every SCAN_DIV clocks
        prev = key_row;
        since = 0;
        changes = 0;
        repeat (100) begin
            @(negedge clk);
            since++;
            if (key_row != prev) begin
                check("scan_row_seq", key_row, {prev[2:0], prev[3]});
                check("scan_row_period", since, 4);
                prev = key_row;
                since = 0;
                changes++;
            end
        end
        check("scan_changes", changes, 25);
        check("idle_code", key_code, 4'h0);

        // Press row 2 / col 1
        keys[2][1] = 1'b1;
        exp_q.push_back(4'h9);
        wait_held(1'b1, 200, "press_r2c1_held");
        check("press_r2c1_code", key_code, 4'h9);
        check("press_r2c1_row", key_row, 4'b1011);
        repeat (40) @(negedge clk);
        check("hold_row_stays", key_row, 4'b1011);
        check("hold_held_stays", {31'd0, key_held}, 32'd1);

        // Release: held drops after 3 released ticks plus sync delay
        keys[2][1] = 1'b0;
        n = 0;
        while (key_held && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("release_latency", {31'd0, (n >= 11 && n <= 14)}, 32'd1);
        check("release_next_row", key_row, 4'b0111);
        check("release_code_kept", key_code, 4'h9);

        // Short glitch on row 0 / col 0
        wait_row(4'b1110, 50, "glitch_wait_row0");
        keys[0][0] = 1'b1;
        repeat (5) @(negedge clk);
        check("glitch_debounce_entered", key_row, 4'b1110);
        keys[0][0] = 1'b0;
        n = 0;
        while (key_row == 4'b1110 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("glitch_next_row", key_row, 4'b1101);

        // Row 1 with cols 0 and 3 together; row 3 press during HELD ignored
        keys[1][0] = 1'b1;
        keys[1][3] = 1'b1;
        exp_q.push_back(4'h4);
        wait_held(1'b1, 200, "multi_held");
        check("multi_code", key_code, 4'h4);
        keys[3][2] = 1'b1;
        repeat (30) @(negedge clk);
        check("held_ignore_row", key_row, 4'b1101);
        check("held_ignore_code", key_code, 4'h4);
        check("held_ignore_held", {31'd0, key_held}, 32'd1);
        keys = '0;
        wait_held(1'b0, 100, "multi_release");

        // Reset in the middle of DEBOUNCE
        keys[2][1] = 1'b1;
        wait_row(4'b1011, 200, "deb_wait_row2");
        repeat (6) @(negedge clk);
        #2 nRst = 1'b1;
        #1;
        check("async_deb_row", key_row, 4'b1110);
        check("async_deb_held", {31'd0, key_held}, 32'd0);
        check("async_deb_valid", {31'd0, key_valid}, 32'd0);
        @(negedge clk);
        nRst = 1'b0;
        exp_q.push_back(4'h9);
        wait_held(1'b1, 200, "after_deb_rst_held");

        // Reset in the middle of HELD
        repeat (5) @(negedge clk);
        #2 nRst = 1'b1;
        #1;
        check("async_held_row", key_row, 4'b1110);
        check("async_held_held", {31'd0, key_held}, 32'd0);
        check("async_held_valid", {31'd0, key_valid}, 32'd0);
        check("async_held_code", key_code, 4'h0);
        @(negedge clk);
        nRst = 1'b0;
        exp_q.push_back(4'h9);
        wait_held(1'b1, 200, "after_held_rst_held");
        check("after_held_rst_code", key_code, 4'h9);
        keys = '0;
        wait_held(1'b0, 100, "final_release");

        repeat (20) @(negedge clk);
        check("all_valids_seen", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
